// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_pkg                                                             |
// | Shared colour codes, field slices, sizes and scanner state encoding. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package game_pkg;
  localparam int c_num_bullets = 3;
  localparam int c_idx_w       = 3;
  localparam int c_hp_w        = 8;
  localparam int c_acc_w       = 11;

  localparam logic [1:0] c_color_white = 2'd0;
  localparam logic [1:0] c_color_green = 2'd1;
  localparam logic [1:0] c_color_blue  = 2'd2;
  localparam logic [1:0] c_color_inert = 2'd3;

  localparam int c_x_hi = 15;
  localparam int c_x_lo = 8;
  localparam int c_y_hi = 7;
  localparam int c_y_lo = 0;
  localparam int c_w_hi = 15;
  localparam int c_w_lo = 8;
  localparam int c_h_hi = 7;
  localparam int c_h_lo = 0;

  localparam logic [1:0] c_s_idle  = 2'd0;
  localparam logic [1:0] c_s_scan  = 2'd1;
  localparam logic [1:0] c_s_apply = 2'd2;
endpackage
`default_nettype wire

// File: rtl/rect_overlap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rect_overlap                                                         |
// | Combinational 8-bit axis-aligned rectangle overlap test.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rect_overlap (
  input  logic [7:0] ax,
  input  logic [7:0] ay,
  input  logic [7:0] aw,
  input  logic [7:0] ah,
  input  logic [7:0] bx,
  input  logic [7:0] by,
  input  logic [7:0] bw,
  input  logic [7:0] bh,
  output logic       hit
);
  logic [8:0] w_a_right, w_a_bottom, w_b_right, w_b_bottom;
  logic       w_nonzero;

  // 9-bit edges so a rectangle touching 255 does not wrap to the left side
  assign w_a_right  = {1'b0, ax} + {1'b0, aw};
  assign w_a_bottom = {1'b0, ay} + {1'b0, ah};
  assign w_b_right  = {1'b0, bx} + {1'b0, bw};
  assign w_b_bottom = {1'b0, by} + {1'b0, bh};

  // A degenerate rectangle would otherwise pass the strict-less tests
  assign w_nonzero = (aw != 8'd0) && (ah != 8'd0) && (bw != 8'd0) && (bh != 8'd0);

  assign hit = w_nonzero
            && ({1'b0, bx} < w_a_right)
            && ({1'b0, ax} < w_b_right)
            && ({1'b0, by} < w_a_bottom)
            && ({1'b0, ay} < w_b_bottom);
endmodule
`default_nettype wire

// File: rtl/bullet_collision_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bullet_collision_scanner                                             |
// | Per-frame bullet vs. player scan, damage/heal resolve, HP and mask.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bullet_collision_scanner
  import game_pkg::*;
#(
  parameter int NUM_BULLETS = c_num_bullets,
  parameter int IDX_W       = c_idx_w,
  parameter int HP_MAX      = 20,
  parameter int DMG         = 2,
  parameter int HEAL        = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            player_pos,
  input  logic [15:0]            player_size,
  input  logic                   player_moving,
  output logic [IDX_W-1:0]       bullet_index,
  input  logic [15:0]            bullet_pos,
  input  logic [15:0]            bullet_size,
  input  logic [1:0]             bullet_color,
  input  logic                   bullet_render,
  output logic [NUM_BULLETS-1:0] keep_mask,
  output logic [7:0]             hp,
  output logic                   dead,
  output logic                   busy,
  output logic                   done
);
  logic [1:0]               r_state, w_next;
  logic [IDX_W-1:0]         r_idx;
  logic [c_acc_w-1:0]       r_dmg, r_heal, w_dmg_add, w_heal_add;
  logic [NUM_BULLETS-1:0]   r_hit, r_keep, w_slot_bit;
  logic [c_hp_w-1:0]        r_hp, w_hp_new;
  logic                     r_moving, r_done;
  logic                     w_overlap, w_hit, w_start_ok, w_last;
  logic signed [c_acc_w-1:0] w_net;

  rect_overlap u_overlap (
    .ax  (player_pos[c_x_hi:c_x_lo]),
    .ay  (player_pos[c_y_hi:c_y_lo]),
    .aw  (player_size[c_w_hi:c_w_lo]),
    .ah  (player_size[c_h_hi:c_h_lo]),
    .bx  (bullet_pos[c_x_hi:c_x_lo]),
    .by  (bullet_pos[c_y_hi:c_y_lo]),
    .bw  (bullet_size[c_w_hi:c_w_lo]),
    .bh  (bullet_size[c_h_hi:c_h_lo]),
    .hit (w_overlap)
  );

  assign w_hit      = w_overlap && bullet_render;
  assign w_start_ok = start && !dead;
  assign w_last     = (r_idx == IDX_W'(NUM_BULLETS - 1));
  assign w_slot_bit = NUM_BULLETS'(1) << r_idx;

  assign dead      = (r_hp == '0);
  assign hp        = r_hp;
  assign keep_mask = r_keep;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_s_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_s_idle:  if (w_start_ok) w_next = c_s_scan;
      c_s_scan:  if (w_last) w_next = c_s_apply;
      c_s_apply: w_next = c_s_idle;
      default:   w_next = c_s_idle;
    endcase
  end

  always_comb begin
    busy         = (r_state == c_s_scan) || (r_state == c_s_apply);
    bullet_index = (r_state == c_s_scan) ? r_idx : '0;
  end

  // Blue only hurts when the player was moving at frame start
  always_comb begin
    w_dmg_add  = '0;
    w_heal_add = '0;
    if (w_hit) begin
      case (bullet_color)
        c_color_white: w_dmg_add  = c_acc_w'(DMG);
        c_color_green: w_heal_add = c_acc_w'(HEAL);
        c_color_blue:  if (r_moving) w_dmg_add = c_acc_w'(DMG);
        default:       ;
      endcase
    end
  end

  // Damage and heal net out before the clamp
  assign w_net = $signed(c_acc_w'(r_hp)) - $signed(r_dmg) + $signed(r_heal);

  always_comb begin
    w_hp_new = w_net[c_hp_w-1:0];
    if (w_net < 0)
      w_hp_new = '0;
    else if (w_net > $signed(c_acc_w'(HP_MAX)))
      w_hp_new = c_hp_w'(HP_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_dmg    <= '0;
      r_heal   <= '0;
      r_hit    <= '0;
      r_keep   <= '1;
      r_hp     <= c_hp_w'(HP_MAX);
      r_moving <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_s_idle: begin
          if (w_start_ok) begin
            r_idx    <= '0;
            r_dmg    <= '0;
            r_heal   <= '0;
            r_hit    <= '0;
            r_keep   <= '1;
            r_moving <= player_moving;
          end
        end
        c_s_scan: begin
          if (w_hit) r_hit <= r_hit | w_slot_bit;
          r_dmg  <= r_dmg + w_dmg_add;
          r_heal <= r_heal + w_heal_add;
          r_idx  <= w_last ? '0 : r_idx + 1'b1;
        end
        c_s_apply: begin
          r_hp   <= w_hp_new;
          r_keep <= ~r_hit;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bullet_collision_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bullet_collision_scanner                                          |
// | Directed plus randomized frames checked against a behavioural model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bullet_collision_scanner;
  localparam int NB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] player_pos, player_size;
  logic        player_moving = 1'b0;
  logic [2:0]  bullet_index;
  logic [15:0] bullet_pos, bullet_size;
  logic [1:0]  bullet_color;
  logic        bullet_render;
  logic [NB-1:0] keep_mask;
  logic [7:0]  hp;
  logic        dead, busy, done;

  logic [7:0] p_x = 8'h80, p_y = 8'h40, p_w = 8'h10, p_h = 8'h10;
  logic [7:0] b_x[NB], b_y[NB], b_w[NB], b_h[NB];
  logic [1:0] b_c[NB];
  logic       b_r[NB];

  int m_hp = 20;
  logic [NB-1:0] m_mask = '1;
  int n_checks = 0;
  int n_fail = 0;

  bullet_collision_scanner dut (
    .clk(clk), .reset(reset), .start(start),
    .player_pos(player_pos), .player_size(player_size), .player_moving(player_moving),
    .bullet_index(bullet_index), .bullet_pos(bullet_pos), .bullet_size(bullet_size),
    .bullet_color(bullet_color), .bullet_render(bullet_render),
    .keep_mask(keep_mask), .hp(hp), .dead(dead), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign player_pos  = {p_x, p_y};
  assign player_size = {p_w, p_h};

  // Behaves like the bullet store's second read port
  always_comb begin
    bullet_pos = '0; bullet_size = '0; bullet_color = 2'd3; bullet_render = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (int'(bullet_index) == i) begin
        bullet_pos = {b_x[i], b_y[i]};
        bullet_size = {b_w[i], b_h[i]};
        bullet_color = b_c[i];
        bullet_render = b_r[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_b(input int i, input int x, input int y, input int w, input int h,
                       input int c, input bit r);
    b_x[i] = 8'(x); b_y[i] = 8'(y); b_w[i] = 8'(w); b_h[i] = 8'(h);
    b_c[i] = 2'(c); b_r[i] = r;
  endtask

  // Reference: plain integer rectangle arithmetic and colour rules
  task automatic model_frame(input bit mv);
    int dmg, heal, net;
    bit hit;
    dmg = 0; heal = 0;
    for (int i = 0; i < NB; i++) begin
      hit = b_r[i] && b_w[i] > 0 && b_h[i] > 0 && p_w > 0 && p_h > 0
         && int'(b_x[i]) < int'(p_x) + int'(p_w) && int'(p_x) < int'(b_x[i]) + int'(b_w[i])
         && int'(b_y[i]) < int'(p_y) + int'(p_h) && int'(p_y) < int'(b_y[i]) + int'(b_h[i]);
      m_mask[i] = !hit;
      if (hit) begin
        if (b_c[i] == 2'd0 || (b_c[i] == 2'd2 && mv)) dmg += 2;
        if (b_c[i] == 2'd1) heal += 1;
      end
    end
    net = m_hp - dmg + heal;
    m_hp = (net < 0) ? 0 : (net > 20) ? 20 : net;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_hp = 20; m_mask = '1;
  endtask

  task automatic do_frame(input bit mv, input bit hold);
    int k;
    bit acc;
    acc = (m_hp != 0);
    if (acc) model_frame(mv);
    @(negedge clk); start = 1'b1; player_moving = mv;
    @(posedge clk); #1;
    chk("busy_after_start", 32'(busy), 32'(acc));
    @(negedge clk); start = hold;
    @(negedge clk); start = 1'b0;
    if (!acc) begin
      chk("dead_stays_idle", 32'(busy), 0);
      chk("dead_hp", 32'(hp), 0);
      return;
    end
    k = 1;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (done) break;
    end
    chk("done_latency", 32'(k), NB + 1);
    chk("hp", 32'(hp), 32'(m_hp));
    chk("keep_mask", 32'(keep_mask), 32'(m_mask));
    chk("dead", 32'(dead), 32'(m_hp == 0));
    chk("busy_after_done", 32'(busy), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) set_b(i, 8'h80 + 4 * i, 8'h13, 8, 8, 0, 1'b1);
    do_reset();
    #1;
    chk("rst_hp", 32'(hp), 20);
    chk("rst_mask", 32'(keep_mask), 32'h7);
    chk("rst_dead", 32'(dead), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_index", 32'(bullet_index), 0);

    do_frame(1'b0, 1'b0);
    chk("no_overlap_hp", 32'(hp), 20);
    chk("no_overlap_mask", 32'(keep_mask), 32'h7);

    set_b(0, 8'h84, 8'h44, 8, 8, 0, 1'b1);
    do_frame(1'b0, 1'b0);
    chk("white_hp", 32'(hp), 18);
    chk("white_mask", 32'(keep_mask), 32'h6);

    set_b(0, 8'h80, 8'h13, 8, 8, 0, 1'b1);
    set_b(1, 8'h84, 8'h44, 8, 8, 2, 1'b1);
    do_frame(1'b0, 1'b0);
    chk("blue_still_hp", 32'(hp), 18);
    chk("blue_still_mask", 32'(keep_mask), 32'h5);
    do_frame(1'b1, 1'b1);
    chk("blue_moving_hp", 32'(hp), 16);

    do_reset();
    set_b(1, 8'h84, 8'h13, 8, 8, 0, 1'b1);
    set_b(2, 8'h84, 8'h44, 8, 8, 1, 1'b1);
    do_frame(1'b0, 1'b0);
    chk("green_sat_hp", 32'(hp), 20);
    chk("green_sat_mask", 32'(keep_mask), 32'h3);

    set_b(2, 8'h88, 8'h13, 8, 8, 1, 1'b1);
    set_b(0, 8'h90, 8'h44, 8, 8, 0, 1'b1);
    do_frame(1'b0, 1'b0);
    chk("edge_adjacent_mask", 32'(keep_mask), 32'h7);
    set_b(0, 8'h8f, 8'h44, 8, 8, 0, 1'b1);
    do_frame(1'b0, 1'b0);
    chk("edge_inside_mask", 32'(keep_mask), 32'h6);
    chk("edge_inside_hp", 32'(hp), 18);

    for (int f = 0; f < 40; f++) begin
      p_x = 8'($urandom_range(8'h20, 8'hd0));
      p_y = 8'($urandom_range(8'h20, 8'hd0));
      p_w = 8'($urandom_range(0, 24));
      p_h = 8'($urandom_range(0, 24));
      for (int i = 0; i < NB; i++)
        set_b(i, int'(p_x) + $urandom_range(0, 48) - 16, int'(p_y) + $urandom_range(0, 48) - 16,
              $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 3),
              ($urandom_range(0, 3) != 0));
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (m_hp == 0) do_reset();
    end

    do_reset();
    p_x = 8'h80; p_y = 8'h40; p_w = 8'h10; p_h = 8'h10;
    set_b(0, 8'h84, 8'h44, 8, 8, 0, 1'b1);
    set_b(1, 8'h80, 8'h13, 8, 8, 0, 1'b1);
    set_b(2, 8'h88, 8'h13, 8, 8, 0, 1'b1);
    for (int f = 0; f < 10; f++) do_frame(1'b0, 1'b0);
    chk("death_hp", 32'(hp), 0);
    chk("death_dead", 32'(dead), 1);
    do_frame(1'b0, 1'b0);

    do_reset();
    do_frame(1'b0, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_hp = 20; m_mask = '1;
    chk("abort_hp", 32'(hp), 20);
    chk("abort_mask", 32'(keep_mask), 32'h7);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_index", 32'(bullet_index), 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_hp_held", 32'(hp), 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
